// File: rtl/tlk2711_rx_buf_ctrl.sv
//------------------------------------------------------------------------------
// tlk2711_rx_buf_ctrl : DDR slot-ring manager for the TLK2711 RX link
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tlk2711_rx_buf_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DLEN_WIDTH = 16,
  parameter int SLOT_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_soft_rst,
  input  logic                  i_cfg_en,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [DLEN_WIDTH-1:0] i_slot_size,
  input  logic [SLOT_WIDTH-1:0] i_slot_num,
  input  logic                  i_frame_done,
  input  logic                  i_sw_release,
  output logic                  o_rx_start,
  output logic [ADDR_WIDTH-1:0] o_rx_base_addr,
  output logic                  o_frame_irq,
  output logic [SLOT_WIDTH-1:0] o_wr_idx,
  output logic [SLOT_WIDTH-1:0] o_rd_idx,
  output logic [SLOT_WIDTH:0]   o_fill_cnt,
  output logic                  o_full,
  output logic                  o_overflow,
  output logic                  o_rel_err
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ARM       = 2'd1,
    S_BUSY      = 2'd2,
    S_FULL_WAIT = 2'd3
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] r_acc;
  logic [ADDR_WIDTH-1:0] r_rx_addr;
  logic [DLEN_WIDTH-1:0] r_size;
  logic [SLOT_WIDTH:0]   r_n;
  logic [SLOT_WIDTH:0]   r_fill;
  logic [SLOT_WIDTH-1:0] r_wr_idx;
  logic [SLOT_WIDTH-1:0] r_rd_idx;
  logic                  r_rx_start;
  logic                  r_irq;
  logic                  r_full;
  logic                  r_ovf;
  logic                  r_rel_err;

  logic                  w_busy;
  logic                  w_done;
  logic                  w_rel_ok;
  logic [SLOT_WIDTH:0]   w_last;
  logic [SLOT_WIDTH:0]   w_fill_next;
  logic                  w_wr_wrap;
  logic                  w_rd_wrap;

  assign w_busy    = (r_state == S_BUSY);
  assign w_done    = i_frame_done && w_busy;
  assign w_rel_ok  = i_sw_release && (r_fill != '0);
  assign w_last    = r_n - {{SLOT_WIDTH{1'b0}}, 1'b1};
  assign w_wr_wrap = ({1'b0, r_wr_idx} == w_last);
  assign w_rd_wrap = ({1'b0, r_rd_idx} == w_last);

  // A store and a release in the same cycle cancel out.
  always_comb begin
    w_fill_next = r_fill;
    if (w_done && !w_rel_ok) begin
      w_fill_next = r_fill + {{SLOT_WIDTH{1'b0}}, 1'b1};
    end else if (!w_done && w_rel_ok) begin
      w_fill_next = r_fill - {{SLOT_WIDTH{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_base     <= '0;
      r_acc      <= '0;
      r_rx_addr  <= '0;
      r_size     <= '0;
      r_n        <= '0;
      r_fill     <= '0;
      r_wr_idx   <= '0;
      r_rd_idx   <= '0;
      r_rx_start <= 1'b0;
      r_irq      <= 1'b0;
      r_full     <= 1'b0;
      r_ovf      <= 1'b0;
      r_rel_err  <= 1'b0;
    end else if (i_soft_rst) begin
      r_state    <= S_IDLE;
      r_base     <= '0;
      r_acc      <= '0;
      r_rx_addr  <= '0;
      r_size     <= '0;
      r_n        <= '0;
      r_fill     <= '0;
      r_wr_idx   <= '0;
      r_rd_idx   <= '0;
      r_rx_start <= 1'b0;
      r_irq      <= 1'b0;
      r_full     <= 1'b0;
      r_ovf      <= 1'b0;
      r_rel_err  <= 1'b0;
    end else begin
      r_rx_start <= 1'b0;
      r_irq      <= w_done;
      if (i_frame_done && !w_busy) r_ovf <= 1'b1;
      if (i_sw_release && (r_fill == '0)) r_rel_err <= 1'b1;
      r_fill <= w_fill_next;
      // r_n is zero until configured, so an unconfigured ring never reads full
      r_full <= (r_n != '0) && (w_fill_next == r_n);
      if (w_rel_ok) r_rd_idx <= w_rd_wrap ? '0 : r_rd_idx + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (i_cfg_en) begin
            r_base   <= i_base_addr;
            r_size   <= i_slot_size;
            r_n      <= {1'b0, i_slot_num} + {{SLOT_WIDTH{1'b0}}, 1'b1};
            r_fill   <= '0;
            r_full   <= 1'b0;
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_acc    <= i_base_addr;
            r_state  <= S_ARM;
          end
        end
        S_ARM: begin
          if (w_fill_next < r_n) begin
            r_rx_start <= 1'b1;
            r_rx_addr  <= r_acc;
            r_state    <= S_BUSY;
          end else begin
            r_state <= S_FULL_WAIT;
          end
        end
        S_BUSY: begin
          if (w_done) begin
            if (w_wr_wrap) begin
              r_wr_idx <= '0;
              r_acc    <= r_base;
            end else begin
              r_wr_idx <= r_wr_idx + 1'b1;
              r_acc    <= r_acc + ADDR_WIDTH'(r_size);
            end
            r_state <= i_cfg_en ? S_ARM : S_IDLE;
          end
        end
        S_FULL_WAIT: begin
          if (!i_cfg_en)     r_state <= S_IDLE;
          else if (w_rel_ok) r_state <= S_ARM;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rx_start     = r_rx_start;
  assign o_rx_base_addr = r_rx_addr;
  assign o_frame_irq    = r_irq;
  assign o_wr_idx       = r_wr_idx;
  assign o_rd_idx       = r_rd_idx;
  assign o_fill_cnt     = r_fill;
  assign o_full         = r_full;
  assign o_overflow     = r_ovf;
  assign o_rel_err      = r_rel_err;

endmodule

`default_nettype wire
